// File: rtl/test_mac_pkg.sv
// Shared constants for the systolic-array processing elements.
// The default data width is common to test_mac and the enclosing array.
package test_mac_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/mac_mul.sv
// Combinational unsigned multiplier for one processing element.
// Only the low DATA_WIDTH bits of the product are kept.
module mac_mul
  import test_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] p
);

  // The result is sized to DATA_WIDTH, so the high half of the full product is dropped.
  assign p = a * b;

endmodule

// File: rtl/test_mac.sv
// Systolic-array MAC element: forwards A/B east/south and accumulates A*B.
// All outputs come straight from registers so elements chain with no glue.
module test_mac
  import test_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] B_out,
  output logic [DATA_WIDTH-1:0] C_out
);

  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH-1:0] c_r;
  logic [DATA_WIDTH-1:0] product_s;

  mac_mul #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .a(A_in),
    .b(B_in),
    .p(product_s)
  );

  // Operand forwarding and wrapping accumulate; reset discards the in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= {DATA_WIDTH{1'b0}};
      b_r <= {DATA_WIDTH{1'b0}};
      c_r <= {DATA_WIDTH{1'b0}};
    end else begin
      a_r <= A_in;
      b_r <= B_in;
      c_r <= c_r + product_s;
    end
  end

  assign A_out = a_r;
  assign B_out = b_r;
  assign C_out = c_r;

endmodule

// File: tb/tb_test_mac.sv
// Directed self-checking bench for test_mac: single element plus a 3-element chain.
// Expected outputs are queued when stimulus is driven and popped after the edge.
module tb_test_mac;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic [DW-1:0] c_out;

  logic [DW-1:0] ch_a [0:3];
  logic [DW-1:0] ch_b [0:3];
  logic [DW-1:0] ch_c [0:2];

  typedef struct {
    string         tag;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] ec;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  test_mac #(.DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .A_in(a_in), .B_in(b_in),
    .A_out(a_out), .B_out(b_out), .C_out(c_out)
  );

  test_mac #(.DATA_WIDTH(DW)) u_pe0 (
    .clk(clk), .rst(rst), .A_in(ch_a[0]), .B_in(ch_b[0]),
    .A_out(ch_a[1]), .B_out(ch_b[1]), .C_out(ch_c[0])
  );
  test_mac #(.DATA_WIDTH(DW)) u_pe1 (
    .clk(clk), .rst(rst), .A_in(ch_a[1]), .B_in(ch_b[1]),
    .A_out(ch_a[2]), .B_out(ch_b[2]), .C_out(ch_c[1])
  );
  test_mac #(.DATA_WIDTH(DW)) u_pe2 (
    .clk(clk), .rst(rst), .A_in(ch_a[2]), .B_in(ch_b[2]),
    .A_out(ch_a[3]), .B_out(ch_b[3]), .C_out(ch_c[2])
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the single element and check its outputs after the edge.
  task automatic step(input string tag, input logic r, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] ea,
                      input logic [DW-1:0] eb, input logic [DW-1:0] ec);
    exp_t e;
    rst  = r;
    a_in = a;
    b_in = b;
    sb.push_back('{tag, ea, eb, ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".A_out"}, a_out, e.ea);
    check({e.tag, ".B_out"}, b_out, e.eb);
    check({e.tag, ".C_out"}, c_out, e.ec);
  endtask

  initial begin
    exp_t e;
    rst     = 1'b1;
    a_in    = 32'd0;
    b_in    = 32'd0;
    ch_a[0] = 32'd0;
    ch_b[0] = 32'd0;

    // Reset ignores operands
    step("rst",   1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0);
    // Accumulate, then zero operand holds
    step("acc1",  1'b0, 32'd3, 32'd4, 32'd3, 32'd4, 32'd12);
    step("acc2",  1'b0, 32'd2, 32'd5, 32'd2, 32'd5, 32'd22);
    step("zero",  1'b0, 32'd0, 32'd9, 32'd0, 32'd9, 32'd22);
    step("zeroB", 1'b0, 32'd7, 32'd0, 32'd7, 32'd0, 32'd22);
    // Sum wraps
    step("rst2",  1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step("wrap1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    step("wrap2", 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'h0000_0000);
    // Product truncation
    step("rst3",  1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step("trunc1", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    step("trunc2", 1'b0, 32'h0001_0001, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 32'h0001_0000);
    // Mid-run reset discards in-flight product
    step("rst4",  1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step("mid1",  1'b0, 32'd3, 32'd4, 32'd3, 32'd4, 32'd12);
    step("mid2",  1'b0, 32'd2, 32'd5, 32'd2, 32'd5, 32'd22);
    step("midrst", 1'b1, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0);
    step("resume", 1'b0, 32'd1, 32'd2, 32'd1, 32'd2, 32'd2);

    // Chain: reset, then inject A=2,B=3 for one cycle followed by zeros
    step("rst5",  1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("chain_rst.C%0d", k), ch_c[k], 32'd0);
    end
    rst  = 1'b0;
    a_in = 32'd0;
    b_in = 32'd0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      ch_a[0] = (cyc == 1) ? 32'd2 : 32'd0;
      ch_b[0] = (cyc == 1) ? 32'd3 : 32'd0;
      for (int k = 0; k < 3; k++) begin
        sb.push_back('{$sformatf("chain_c%0d_pe%0d", cyc, k),
                       (cyc == k + 1) ? 32'd2 : 32'd0,
                       (cyc == k + 1) ? 32'd3 : 32'd0,
                       (cyc >= k + 1) ? 32'd6 : 32'd0});
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        e = sb.pop_front();
        check({e.tag, ".A_out"}, ch_a[k+1], e.ea);
        check({e.tag, ".B_out"}, ch_b[k+1], e.eb);
        check({e.tag, ".C_out"}, ch_c[k],   e.ec);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
